// File: rtl/alu_arb_pkg.sv
// Shared encodings for the two-client ALU arbiter: ALU op codes,
// arithmetic/logic select values and the controller state encoding.
package alu_arb_pkg;

    // Logic-mode op codes (arit = 0)
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    // Arithmetic-mode op codes (arit = 1)
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NEGA = 2'b10;
    localparam logic [1:0] OP_NEGB = 2'b11;

    localparam logic ARIT  = 1'b1;
    localparam logic LOGIC = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// 4-bit ALU shared by the arbiter. Arithmetic carry is the carry-out of the
// adder, so SUB reports carry=1 when no borrow occurs. In logic mode the
// carry is 0 and the sign is the result MSB; callers treat both as don't-care.
module alu
    import alu_arb_pkg::*;
(
    output logic [3:0] R,
    output logic       z,
    output logic       c,
    output logic       s,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [1:0] Op,
    input  logic       arit
);

    logic [4:0] sum;

    // Pure combinational result and flag generation
    always_comb begin
        sum = 5'd0;
        R   = 4'd0;
        c   = 1'b0;
        if (arit == ARIT) begin
            case (Op)
                OP_ADD:  sum = {1'b0, A} + {1'b0, B};
                OP_SUB:  sum = {1'b0, A} + {1'b0, ~B} + 5'd1;
                OP_NEGA: sum = {1'b0, ~A} + 5'd1;
                default: sum = {1'b0, ~B} + 5'd1;
            endcase
            R = sum[3:0];
            c = sum[4];
        end else begin
            case (Op)
                OP_AND:  R = A & B;
                OP_OR:   R = A | B;
                OP_XOR:  R = A ^ B;
                default: R = ~A;
            endcase
        end
        z = (R == 4'd0);
        s = R[3];
    end

endmodule

// File: rtl/alu_rr_arb.sv
// Two-way grant logic for the ALU arbiter.
// Default build: round robin; when both clients request, the one not granted
// last wins. The last-grant register resets to 1 so client 0 wins first.
// With ALU_ARB_FIXED_PRIO_EN defined, client 0 always wins a tie and the
// last-grant register does not exist.
module alu_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

`ifdef ALU_ARB_FIXED_PRIO_EN

    logic unused_fixed_prio;
    assign unused_fixed_prio = ^{clk, reset, accept};

    // Client 0 has absolute priority
    always_comb begin
        grant0 = valid0;
        grant1 = valid1 & ~valid0;
    end

`else

    logic last_grant_q;
    logic last_grant_d;

    // Grant selection and last-grant update on acceptance
    always_comb begin
        if (valid0 && valid1) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
        end else begin
            grant0 = valid0;
            grant1 = valid1;
        end
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant1;
        end
    end

    // Last-grant register
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 4-bit ALU between two requesters. A request is accepted in IDLE,
// its operands are latched, the ALU runs in EXEC and the registered result is
// held on the response channel in RESP until the consumer takes it.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (client 0 wins).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic             req0_arit,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    output logic             req0_ack,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic             req1_arit,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    output logic             req1_ack,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_r,
    output logic             rsp_z,
    output logic             rsp_c,
    output logic             rsp_s,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    arb_state_e       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             arit_q, arit_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [3:0]       rsp_r_q, rsp_r_d;
    logic             rsp_z_q, rsp_z_d;
    logic             rsp_c_q, rsp_c_d;
    logic             rsp_s_q, rsp_s_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic       grant0, grant1, accept;
    logic [3:0] alu_r;
    logic       alu_z, alu_c, alu_s;

    alu_rr_arb u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    alu u_alu (alu_r, alu_z, alu_c, alu_s, a_q, b_q, op_q, arit_q);

    // Acks are only offered in IDLE and never while reset is asserted
    always_comb begin
        req0_ack = req0_valid & grant0 & (state_q == ST_IDLE) & ~reset;
        req1_ack = req1_valid & grant1 & (state_q == ST_IDLE) & ~reset;
    end

    // Next-state, operand latch, response and counter logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        arit_d      = arit_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_r_d     = rsp_r_q;
        rsp_z_d     = rsp_z_q;
        rsp_c_d     = rsp_c_q;
        rsp_s_d     = rsp_s_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                    if (grant0) begin
                        op_d   = req0_op;
                        arit_d = req0_arit;
                        a_d    = req0_a;
                        b_d    = req0_b;
                        id_d   = 1'b0;
                    end else begin
                        op_d   = req1_op;
                        arit_d = req1_arit;
                        a_d    = req1_a;
                        b_d    = req1_b;
                        id_d   = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                // Logic-mode carry/sign from the ALU are meaningless; report 0
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_r_d     = alu_r;
                rsp_z_d     = alu_z;
                rsp_c_d     = (arit_q == ARIT) ? alu_c : 1'b0;
                rsp_s_d     = (arit_q == ARIT) ? alu_s : 1'b0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    if (rsp_id_q) begin
                        cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        cnt0_d = cnt0_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'd0;
            arit_q      <= 1'b0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_r_q     <= 4'd0;
            rsp_z_q     <= 1'b0;
            rsp_c_q     <= 1'b0;
            rsp_s_q     <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            arit_q      <= arit_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_r_q     <= rsp_r_d;
            rsp_z_q     <= rsp_z_d;
            rsp_c_q     <= rsp_c_d;
            rsp_s_q     <= rsp_s_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_s     = rsp_s_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed table of single operations, hand-written
// multi-cycle sequences (tie-break, backpressure, reset mid-operation,
// counter wrap) and a randomized phase against a transaction-level model.
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_arit, req0_ack;
    logic [1:0] req0_op;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_arit, req1_ack;
    logic [1:0] req1_op;
    logic [3:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_c, rsp_s;
    logic [3:0] rsp_r;
    logic [7:0] cnt0, cnt1;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_cnt0 = 8'd0;
    logic [7:0] m_cnt1 = 8'd0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_arit  (req0_arit),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ack   (req0_ack),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_arit  (req1_arit),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ack   (req1_ack),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_r      (rsp_r),
        .rsp_z      (rsp_z),
        .rsp_c      (rsp_c),
        .rsp_s      (rsp_s),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    typedef struct {
        logic       id;
        logic [1:0] op;
        logic       arit;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic       z;
        logic       c;
        logic       s;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU from arithmetic rules: returns {r, z, c, s}
    function automatic logic [6:0] alu_ref(input logic [1:0] op, input logic arit,
                                           input logic [3:0] a, input logic [3:0] b);
        int ai = int'(a);
        int bi = int'(b);
        int res = 0;
        logic cy = 1'b0;
        logic [3:0] r;
        if (arit) begin
            case (op)
                2'd0: begin res = ai + bi; cy = (res > 15); end
                2'd1: begin res = ai - bi; cy = (ai >= bi); end
                2'd2: begin res = -ai;     cy = (ai == 0);  end
                default: begin res = -bi;  cy = (bi == 0);  end
            endcase
            r = 4'(res & 15);
            return {r, (r == 4'd0), cy, r[3]};
        end
        case (op)
            2'd0: r = a & b;
            2'd1: r = a | b;
            2'd2: r = a ^ b;
            default: r = ~a;
        endcase
        return {r, (r == 4'd0), 1'b0, 1'b0};
    endfunction

    task automatic set_req(input logic id, input logic v, input logic [1:0] op,
                           input logic arit, input logic [3:0] a, input logic [3:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_arit = arit; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_arit = arit; req0_a = a; req0_b = b;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 2'd0, 1'b1, 4'd1, 4'd1);
        set_req(1'b1, 1'b1, 2'd0, 1'b1, 4'd2, 4'd2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_no_ack", 32'({req0_ack, req1_ack}), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        m_cnt0 = 8'd0;
        m_cnt1 = 8'd0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_r", 32'(rsp_r), 32'd0);
        check("rst_cnt", 32'({cnt0, cnt1}), 32'd0);
        @(posedge clk); #1;
    endtask

    // One operation from a single requester with rsp_ready held high.
    // Starts and ends just after a rising edge.
    task automatic do_op(input string tag, input logic id, input logic [1:0] op,
                         input logic arit, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] er, input logic ez, input logic ec, input logic es);
        bit got = 1'b0;
        rsp_ready = 1'b1;
        set_req(id, 1'b1, op, arit, a, b);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((id ? req1_ack : req0_ack) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_ack"}, 32'(got), 32'd1);
        if (!got) return;
        check({tag, "_other_ack"}, 32'(id ? req0_ack : req1_ack), 32'd0);
        @(posedge clk); #1;
        set_req(id, 1'b0, ~op, ~arit, ~a, ~b);
        @(negedge clk);
        check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp"}, 32'({rsp_id, rsp_r, rsp_z, rsp_c, rsp_s}),
              32'({id, er, ez, ec, es}));
        @(posedge clk); #1;
        if (id) m_cnt1++; else m_cnt0++;
        @(negedge clk);
        check({tag, "_after_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_cnt"}, 32'({cnt0, cnt1}), 32'({m_cnt0, m_cnt1}));
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       exp_w;
        logic [6:0] e;
        logic [3:0] ra, rb;
        logic [1:0] rop;
        logic       rar;

        tbl[0] = '{1'b0, 2'b00, 1'b1, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 2'b11, 1'b0, 4'b1111, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 2'b10, 1'b0, 4'b1010, 4'b0110, 4'b1100, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 2'b00, 1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 2'b01, 1'b1, 4'b0010, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 2'b10, 1'b1, 4'b0101, 4'b0000, 4'b1011, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 2'b11, 1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 2'b00, 1'b0, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 2'b11, 1'b0, 4'b0000, 4'b1001, 4'b1111, 1'b0, 1'b0, 1'b0};

        apply_reset();

        // Both requesters valid straight out of reset
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 2'b01, 1'b1, 4'b0011, 4'b0011);
        set_req(1'b1, 1'b1, 2'b01, 1'b1, 4'b0011, 4'b0011);
        for (int i = 0; i < 3; i++) begin
            exp_w = FIXED_PRIO ? 1'b0 : 1'((i % 2) != 0);
            @(negedge clk);
            check("tie_ack", 32'({req0_ack, req1_ack}), 32'({~exp_w, exp_w}));
            @(posedge clk); #1;
            @(negedge clk);
            check("tie_exec_noack", 32'({req0_ack, req1_ack}), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("tie_rsp", 32'({rsp_valid, rsp_id, rsp_r, rsp_z, rsp_c, rsp_s}),
                  32'({1'b1, exp_w, 4'b0000, 1'b1, 1'b1, 1'b0}));
            @(posedge clk); #1;
            if (exp_w) m_cnt1++; else m_cnt0++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure: response held for 5 cycles while req1 waits
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 2'b00, 1'b1, 4'd5, 4'd9);
        @(negedge clk);
        check("bp_ack0", 32'(req0_ack), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set_req(1'b1, 1'b1, 2'b00, 1'b1, 4'd1, 4'd2);
        @(negedge clk);
        check("bp_exec_noack", 32'(req1_ack), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) rsp_ready = 1'b1;
            @(negedge clk);
            check("bp_hold_rsp", 32'({rsp_valid, rsp_id, rsp_r, rsp_z, rsp_c, rsp_s}),
                  32'({1'b1, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b1}));
            check("bp_hold_noack", 32'({req0_ack, req1_ack}), 32'd0);
            check("bp_hold_cnt", 32'({cnt0, cnt1}), 32'({m_cnt0, m_cnt1}));
            @(posedge clk); #1;
        end
        m_cnt0++;
        @(negedge clk);
        check("bp_done_valid", 32'(rsp_valid), 32'd0);
        check("bp_idle_ack1", 32'(req1_ack), 32'd1);
        check("bp_done_cnt", 32'({cnt0, cnt1}), 32'({m_cnt0, m_cnt1}));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_rsp1", 32'({rsp_valid, rsp_id, rsp_r, rsp_z, rsp_c, rsp_s}),
              32'({1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0}));
        @(posedge clk); #1;
        m_cnt1++;
        @(negedge clk);
        check("bp_rsp1_cnt", 32'({cnt0, cnt1}), 32'({m_cnt0, m_cnt1}));
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_op("tbl", tbl[i].id, tbl[i].op, tbl[i].arit, tbl[i].a, tbl[i].b,
                  tbl[i].r, tbl[i].z, tbl[i].c, tbl[i].s);
        end

        // Reset while an operation is in EXEC
        apply_reset();
        set_req(1'b0, 1'b1, 2'b00, 1'b1, 4'd1, 4'd1);
        @(negedge clk);
        check("rexec_ack0", 32'(req0_ack), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rexec_no_rsp", 32'(rsp_valid), 32'd0);
            check("rexec_cnt0", 32'(cnt0), 32'd0);
            @(posedge clk); #1;
        end

        // 256 completed req0 operations wrap cnt0
        for (int i = 0; i < 256; i++) begin
            rop = 2'($urandom_range(0, 3));
            rar = 1'($urandom_range(0, 1));
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            e   = alu_ref(rop, rar, ra, rb);
            do_op("wrap", 1'b0, rop, rar, ra, rb, e[6:3], e[2], e[1], e[0]);
        end
        @(negedge clk);
        check("wrap_cnt0_zero", 32'(cnt0), 32'd0);
        @(posedge clk); #1;

        // Randomized traffic against the transaction model
        apply_reset();
        begin
            bit         busy = 1'b0;
            logic       last = 1'b1;
            int         ack_cyc = 0;
            logic [7:0] exp_rsp = 8'd0;
            logic       w;
            logic       ea0, ea1, erv;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                set_req(1'b0, 1'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)));
                set_req(1'b1, 1'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)));
                rsp_ready = 1'($urandom_range(0, 9) < 7);
                @(negedge clk);
                ea0 = 1'b0;
                ea1 = 1'b0;
                w   = 1'b0;
                if (!busy && (req0_valid || req1_valid)) begin
                    if (req0_valid && req1_valid) w = FIXED_PRIO ? 1'b0 : ~last;
                    else                          w = req1_valid;
                    ea0 = ~w;
                    ea1 = w;
                end
                erv = busy && (cyc >= ack_cyc + 2);
                check("rnd_ack", 32'({req0_ack, req1_ack}), 32'({ea0, ea1}));
                check("rnd_rsp_valid", 32'(rsp_valid), 32'(erv));
                if (erv) begin
                    check("rnd_rsp", 32'({rsp_id, rsp_r, rsp_z, rsp_c, rsp_s}), 32'(exp_rsp));
                end
                check("rnd_cnt", 32'({cnt0, cnt1}), 32'({m_cnt0, m_cnt1}));
                if (erv && rsp_ready) begin
                    busy = 1'b0;
                    if (exp_rsp[7]) m_cnt1++; else m_cnt0++;
                end else if (ea0 || ea1) begin
                    busy    = 1'b1;
                    ack_cyc = cyc;
                    last    = w;
                    exp_rsp = w ? {1'b1, alu_ref(req1_op, req1_arit, req1_a, req1_b)}
                                : {1'b0, alu_ref(req0_op, req0_arit, req0_a, req0_b)};
                end
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
